// File: rtl/xvga_pkg.sv
// Shared 1024x768@60 raster constants, the sync-bundle type and the raster decode
// used by xvga_timing_gen and its delay line.
package xvga_pkg;

  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;

  localparam logic [HCOUNT_W-1:0] H_ACTIVE = 11'd1024;
  localparam logic [HCOUNT_W-1:0] H_FP     = 11'd24;
  localparam logic [HCOUNT_W-1:0] H_SYNC   = 11'd136;
  localparam logic [HCOUNT_W-1:0] H_BP     = 11'd160;
  localparam logic [HCOUNT_W-1:0] H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [HCOUNT_W-1:0] H_MAX    = H_TOTAL - 11'd1;

  localparam logic [VCOUNT_W-1:0] V_ACTIVE = 10'd768;
  localparam logic [VCOUNT_W-1:0] V_FP     = 10'd3;
  localparam logic [VCOUNT_W-1:0] V_SYNC   = 10'd6;
  localparam logic [VCOUNT_W-1:0] V_BP     = 10'd29;
  localparam logic [VCOUNT_W-1:0] V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam logic [VCOUNT_W-1:0] V_MAX    = V_TOTAL - 10'd1;

  // Sync windows are half-open: [START, END).
  localparam logic [HCOUNT_W-1:0] H_SYNC_START = H_ACTIVE + H_FP;
  localparam logic [HCOUNT_W-1:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [VCOUNT_W-1:0] V_SYNC_START = V_ACTIVE + V_FP;
  localparam logic [VCOUNT_W-1:0] V_SYNC_END   = V_SYNC_START + V_SYNC;

  typedef struct packed {
    logic blank;
    logic hsync;
    logic vsync;
  } sync_t;

  // Register value of the aligned outputs at (0,0) and the all-inactive delay fill.
  localparam sync_t SYNC_AT_ORIGIN = '{blank: 1'b0, hsync: 1'b1, vsync: 1'b1};
  localparam sync_t SYNC_IDLE      = '{blank: 1'b1, hsync: 1'b1, vsync: 1'b1};

  function automatic sync_t raster_sync(input logic [HCOUNT_W-1:0] h,
                                        input logic [VCOUNT_W-1:0] v);
    sync_t s;
    s.blank = (h >= H_ACTIVE) || (v >= V_ACTIVE);
    s.hsync = !((h >= H_SYNC_START) && (h < H_SYNC_END));
    s.vsync = !((v >= V_SYNC_START) && (v < V_SYNC_END));
    return s;
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// DEPTH-stage shift register with async reset to RESET_VAL; DEPTH=0 is a wire.
module sync_delay_line #(
  parameter int               WIDTH     = 1,
  parameter int               DEPTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign q = d;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_q [DEPTH];
      logic [WIDTH-1:0] stage_d [DEPTH];

      always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
          stage_d[i] = stage_q[i-1];
        end
      end

      // NOTE: this array is a handful of flops feeding the pins, not a RAM, so every
      // stage is reset; a reset-less pipe would drive garbage sync pulses after reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= RESET_VAL;
          end
        end else begin
          stage_q <= stage_d;
        end
      end

      assign q = stage_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/xvga_timing_gen.sv
// 1024x768@60 raster counter and sync generator on clk65.
// Optional macro XVGA_FRAME_COUNT_EN enables the 8-bit frame_count register.
module xvga_timing_gen
  import xvga_pkg::*;
#(
  parameter int PIPE_DELAY = 1
) (
  input  logic                clk65,
  input  logic                rst_n,
  output logic [HCOUNT_W-1:0] hcount,
  output logic [VCOUNT_W-1:0] vcount,
  output logic                blank,
  output logic                hsync,
  output logic                vsync,
  output logic                blank_d,
  output logic                hsync_d,
  output logic                vsync_d,
  output logic                new_frame,
  output logic [7:0]          frame_count
);

  logic [HCOUNT_W-1:0] hcount_q, hcount_d;
  logic [VCOUNT_W-1:0] vcount_q, vcount_d;
  sync_t               sync_q, sync_d;
  logic                new_frame_q, new_frame_d;
  logic [2:0]          sync_dly;

  // NOTE: combinational logic uses blocking '=' and assigns every output first,
  // so each path has a value and no latch is inferred.
  always_comb begin
    hcount_d = hcount_q + 1'b1;
    vcount_d = vcount_q;
    if (hcount_q == H_MAX) begin
      hcount_d = '0;
      vcount_d = (vcount_q == V_MAX) ? '0 : vcount_q + 1'b1;
    end
    // Decoding the next counts keeps the sync flops in step with the count flops.
    sync_d      = raster_sync(hcount_d, vcount_d);
    new_frame_d = (hcount_d == '0) && (vcount_d == '0);
  end

  // NOTE: state uses non-blocking '<=' so all flops sample pre-edge values together.
  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) begin
      hcount_q    <= '0;
      vcount_q    <= '0;
      sync_q      <= SYNC_AT_ORIGIN;
      new_frame_q <= 1'b0;
    end else begin
      hcount_q    <= hcount_d;
      vcount_q    <= vcount_d;
      sync_q      <= sync_d;
      new_frame_q <= new_frame_d;
    end
  end

  assign hcount    = hcount_q;
  assign vcount    = vcount_q;
  assign blank     = sync_q.blank;
  assign hsync     = sync_q.hsync;
  assign vsync     = sync_q.vsync;
  assign new_frame = new_frame_q;

  sync_delay_line #(
    .WIDTH    (3),
    .DEPTH    (PIPE_DELAY),
    .RESET_VAL(SYNC_IDLE)
  ) u_sync_delay (
    .clk  (clk65),
    .rst_n(rst_n),
    .d    (sync_q),
    .q    (sync_dly)
  );

  assign {blank_d, hsync_d, vsync_d} = sync_dly;

`ifdef XVGA_FRAME_COUNT_EN
  logic [7:0] frame_count_q, frame_count_d;

  // Counts on the edge that ends the new_frame cycle; 8-bit wrap is intended.
  always_comb frame_count_d = frame_count_q + {7'd0, new_frame_q};

  always_ff @(posedge clk65 or negedge rst_n) begin
    if (!rst_n) frame_count_q <= '0;
    else        frame_count_q <= frame_count_d;
  end

  assign frame_count = frame_count_q;
`else
  assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_xvga_timing_gen.sv
// Directed bench for xvga_timing_gen: reset, line, frame edges, delay alignment,
// mid-frame reset and frame counter; long raster stretches are skipped by preloading counts.
module tb_xvga_timing_gen;

  logic clk65 = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk65 = ~clk65;

  int checks   = 0;
  int failures = 0;

  logic [10:0] hcount, hcount_p0, hcount_p3;
  logic [9:0]  vcount, vcount_p0, vcount_p3;
  logic        blank, hsync, vsync, blank_d, hsync_d, vsync_d, new_frame;
  logic        blank_p0, hsync_p0, vsync_p0, blank_d_p0, hsync_d_p0, vsync_d_p0, new_frame_p0;
  logic        blank_p3, hsync_p3, vsync_p3, blank_d_p3, hsync_d_p3, vsync_d_p3, new_frame_p3;
  logic [7:0]  frame_count, frame_count_p0, frame_count_p3;

  xvga_timing_gen #(.PIPE_DELAY(1)) dut (
    .clk65(clk65), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .blank(blank), .hsync(hsync), .vsync(vsync),
    .blank_d(blank_d), .hsync_d(hsync_d), .vsync_d(vsync_d),
    .new_frame(new_frame), .frame_count(frame_count)
  );

  xvga_timing_gen #(.PIPE_DELAY(0)) dut_p0 (
    .clk65(clk65), .rst_n(rst_n), .hcount(hcount_p0), .vcount(vcount_p0),
    .blank(blank_p0), .hsync(hsync_p0), .vsync(vsync_p0),
    .blank_d(blank_d_p0), .hsync_d(hsync_d_p0), .vsync_d(vsync_d_p0),
    .new_frame(new_frame_p0), .frame_count(frame_count_p0)
  );

  xvga_timing_gen #(.PIPE_DELAY(3)) dut_p3 (
    .clk65(clk65), .rst_n(rst_n), .hcount(hcount_p3), .vcount(vcount_p3),
    .blank(blank_p3), .hsync(hsync_p3), .vsync(vsync_p3),
    .blank_d(blank_d_p3), .hsync_d(hsync_d_p3), .vsync_d(vsync_d_p3),
    .new_frame(new_frame_p3), .frame_count(frame_count_p3)
  );

`ifdef XVGA_FRAME_COUNT_EN
  localparam int FC_AFTER_FIRST = 1;
  localparam int FC_AFTER_WRAP  = 0;
  localparam int FC_AFTER_257   = 1;
`else
  localparam int FC_AFTER_FIRST = 0;
  localparam int FC_AFTER_WRAP  = 0;
  localparam int FC_AFTER_257   = 0;
`endif

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Preload the main DUT's counters so the next edge advances from (h,v).
  logic [10:0] jump_h;
  logic [9:0]  jump_v;
  logic [7:0]  fc_load = 8'd255;

  task jump(input int h, input int v, input bit load_fc);
    @(negedge clk65);
    jump_h = 11'(h);
    jump_v = 10'(v);
    force dut.hcount_q = jump_h;
    force dut.vcount_q = jump_v;
`ifdef XVGA_FRAME_COUNT_EN
    if (load_fc) force dut.frame_count_q = fc_load;
`endif
    #1;
    release dut.hcount_q;
    release dut.vcount_q;
`ifdef XVGA_FRAME_COUNT_EN
    if (load_fc) release dut.frame_count_q;
`endif
  endtask

  // Raster successor used to check every step of the counters.
  function automatic int next_h(input int h);
    return (h == 1343) ? 0 : h + 1;
  endfunction
  function automatic int next_v(input int h, input int v);
    if (h != 1343) return v;
    return (v == 805) ? 0 : v + 1;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   eh, ev, ph, pv;
    int   hmis, vmis, hs_fall, hs_rise, hs_low, bl_rise, hsd_fall, bd3_rise, p0_mis, nf_cnt;
    int   seq_err, vs_mis, bl_mis, vs_fall_v, vs_fall_h, vs_rise_v, vs_low, nf_h, nf_v;
    logic prev_hs, prev_bl, prev_hsd, prev_bd3, prev_vs;

    // ---- reset ----
    repeat (3) @(negedge clk65);
    check("rst_hcount", hcount, 0);
    check("rst_vcount", vcount, 0);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_blank", blank, 0);
    check("rst_blank_d", blank_d, 1);
    check("rst_blank_d_p3", blank_d_p3, 1);
    check("rst_new_frame", new_frame, 0);
    repeat (2) @(negedge clk65);
    rst_n = 1'b1;
    @(negedge clk65);
    check("first_hcount", hcount, 1);
    check("first_vcount", vcount, 0);
    check("first_new_frame", new_frame, 0);

    // ---- one line, plus delay alignment for depths 0, 1 and 3 ----
    hmis = 0; vmis = 0; hs_fall = -1; hs_rise = -1; hs_low = 0; bl_rise = -1;
    hsd_fall = -1; bd3_rise = -1; p0_mis = 0; nf_cnt = 0;
    prev_hs = hsync; prev_bl = blank; prev_hsd = hsync_d; prev_bd3 = blank_d_p3;
    for (int i = 0; i < 1343; i++) begin
      @(negedge clk65);
      eh = (i + 2) % 1344;
      ev = (i == 1342) ? 1 : 0;
      if (int'(hcount) != eh) hmis++;
      if (int'(vcount) != ev) vmis++;
      if (prev_hs && !hsync && hs_fall < 0) hs_fall = int'(hcount);
      if (!prev_hs && hsync && hs_rise < 0) hs_rise = int'(hcount);
      if (!hsync) hs_low++;
      if (!prev_bl && blank && bl_rise < 0) bl_rise = int'(hcount);
      if (prev_hsd && !hsync_d && hsd_fall < 0) hsd_fall = int'(hcount);
      if (!prev_bd3 && blank_d_p3 && bd3_rise < 0) bd3_rise = int'(hcount_p3);
      if ({blank_d_p0, hsync_d_p0, vsync_d_p0} !== {blank_p0, hsync_p0, vsync_p0}) p0_mis++;
      if (new_frame) nf_cnt++;
      prev_hs = hsync; prev_bl = blank; prev_hsd = hsync_d; prev_bd3 = blank_d_p3;
    end
    check("line_hcount_seq_errs", hmis, 0);
    check("line_vcount_errs", vmis, 0);
    check("hsync_fall_h", hs_fall, 1048);
    check("hsync_rise_h", hs_rise, 1184);
    check("hsync_low_cycles", hs_low, 136);
    check("blank_rise_h", bl_rise, 1024);
    check("hsync_d_p1_fall_h", hsd_fall, 1049);
    check("blank_d_p3_rise_h", bd3_rise, 1027);
    check("p0_passthru_errs", p0_mis, 0);
    check("line_new_frame_cnt", nf_cnt, 0);
    check("wrap_hcount", hcount, 0);
    check("wrap_vcount", vcount, 1);

    // ---- vertical blanking and vsync window, lines 767..779 ----
    jump(1343, 766, 1'b0);
    @(negedge clk65);
    check("jumpA_hcount", hcount, 0);
    check("jumpA_vcount", vcount, 767);
    seq_err = 0; vs_mis = 0; bl_mis = 0; vs_low = 0;
    vs_fall_v = -1; vs_fall_h = -1; vs_rise_v = -1; nf_cnt = 0;
    ph = int'(hcount); pv = int'(vcount); prev_vs = vsync;
    for (int i = 0; i < 12 * 1344; i++) begin
      @(negedge clk65);
      if (int'(hcount) != next_h(ph) || int'(vcount) != next_v(ph, pv)) seq_err++;
      if (vsync !== !(vcount >= 10'd771 && vcount <= 10'd776)) vs_mis++;
      if (blank !== (hcount >= 11'd1024 || vcount >= 10'd768)) bl_mis++;
      if (!vsync) vs_low++;
      if (prev_vs && !vsync && vs_fall_v < 0) begin
        vs_fall_v = int'(vcount); vs_fall_h = int'(hcount);
      end
      if (!prev_vs && vsync && vs_rise_v < 0) vs_rise_v = int'(vcount);
      if (new_frame) nf_cnt++;
      ph = int'(hcount); pv = int'(vcount); prev_vs = vsync;
    end
    check("frameA_seq_errs", seq_err, 0);
    check("vsync_window_errs", vs_mis, 0);
    check("vblank_errs", bl_mis, 0);
    check("vsync_fall_v", vs_fall_v, 771);
    check("vsync_fall_h", vs_fall_h, 0);
    check("vsync_rise_v", vs_rise_v, 777);
    check("vsync_low_cycles", vs_low, 6 * 1344);
    check("frameA_new_frame_cnt", nf_cnt, 0);
    check("frameA_end_vcount", vcount, 779);

    // ---- frame wrap 805 -> 0 and new_frame pulse ----
    jump(1343, 803, 1'b0);
    @(negedge clk65);
    seq_err = 0; bl_mis = 0; nf_cnt = 0; nf_h = -1; nf_v = -1;
    ph = int'(hcount); pv = int'(vcount);
    for (int i = 0; i < 2 * 1344 + 5; i++) begin
      @(negedge clk65);
      if (int'(hcount) != next_h(ph) || int'(vcount) != next_v(ph, pv)) seq_err++;
      if (blank !== (hcount >= 11'd1024 || vcount >= 10'd768)) bl_mis++;
      if (new_frame) begin
        nf_cnt++; nf_h = int'(hcount); nf_v = int'(vcount);
      end
      ph = int'(hcount); pv = int'(vcount);
    end
    check("frameB_seq_errs", seq_err, 0);
    check("frameB_blank_errs", bl_mis, 0);
    check("new_frame_cnt", nf_cnt, 1);
    check("new_frame_h", nf_h, 0);
    check("new_frame_v", nf_v, 0);
    check("frameB_end_hcount", hcount, 5);
    check("frame_count_first", frame_count, FC_AFTER_FIRST);

    // ---- frame counter wrap: frame 256 gives 0, frame 257 gives 1 ----
    jump(1343, 805, 1'b1);
    repeat (5) @(negedge clk65);
    check("frame_count_wrap", frame_count, FC_AFTER_WRAP);
    jump(1343, 805, 1'b0);
    repeat (5) @(negedge clk65);
    check("frame_count_257", frame_count, FC_AFTER_257);

    // ---- asynchronous reset mid-frame ----
    jump(699, 400, 1'b0);
    @(posedge clk65);
    #1;
    check("pre_rst_hcount", hcount, 700);
    check("pre_rst_vcount", vcount, 400);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_rst_hcount", hcount, 0);
    check("async_rst_vcount", vcount, 0);
    check("async_rst_hsync", hsync, 1);
    check("async_rst_blank_d", blank_d, 1);
    check("async_rst_frame_count", frame_count, 0);
    repeat (2) @(negedge clk65);
    rst_n = 1'b1;
    @(negedge clk65);
    check("restart_hcount", hcount, 1);
    check("restart_vcount", vcount, 0);
    check("restart_new_frame", new_frame, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/xvga_timing_gen.md
Name: xvga_timing_gen

Overview:
- Raster timing source for the 1024x768 @ 60 Hz display, running at 65 MHz.
- Drives the hcount/vcount bus consumed by the menu and game pixel generators.
- Also produces hsync, vsync and blank, delayed to line up with those generators' registered pixel outputs at the VGA pins.
- Sits between the clock wizard output (clk65) and every pixel-producing block.

Parameters:
- PIPE_DELAY, 1: cycles of delay applied to hsync_d/vsync_d/blank_d. Range 0..4; 1 matches the one-cycle pixel generators.

Ports:
- clk65  in  1  65 MHz pixel clock, the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- hcount  out  11  current pixel column, 0..1343.
- vcount  out  10  current line, 0..805.
- blank  out  1  high outside the 1024x768 visible area; aligned with hcount/vcount.
- hsync  out  1  active-low horizontal sync; aligned with hcount/vcount.
- vsync  out  1  active-low vertical sync; aligned with hcount/vcount.
- blank_d  out  1  blank delayed by PIPE_DELAY cycles.
- hsync_d  out  1  hsync delayed by PIPE_DELAY cycles.
- vsync_d  out  1  vsync delayed by PIPE_DELAY cycles.
- new_frame  out  1  one-cycle pulse while hcount==0 and vcount==0.
- frame_count  out  8  frame counter; see Optional Feature.

Behaviour:
- Clocking and reset: one clock (clk65). Asynchronous, active-low reset (rst_n).
- Horizontal timing: H_ACTIVE=1024, H_FP=24, H_SYNC=136, H_BP=160, H_TOTAL=1344.
- Vertical timing: V_ACTIVE=768, V_FP=3, V_SYNC=6, V_BP=29, V_TOTAL=806.
- Reset values (asserted asynchronously, held while rst_n=0):
  - hcount=0, vcount=0, blank=0, hsync=1, vsync=1, new_frame=0, frame_count=0.
  - Every delay-line stage is 1 for blank_d/hsync_d/vsync_d (all inactive).
- hcount: increments every clock. Wraps 1343->0.
- vcount: increments only on the cycle hcount wraps. Wraps 805->0 when hcount wraps at vcount=805.
- All outputs are registered. blank/hsync/vsync/new_frame are computed from the next-state counts, so they are valid in the same cycle as the hcount/vcount they describe (zero relative latency).
- blank = (hcount>=1024) | (vcount>=768).
- hsync = 0 exactly for hcount 1048..1183 inclusive (136 cycles), on every line.
- vsync = 0 exactly for vcount 771..776 inclusive, for the whole of those lines.
- new_frame = 1 for exactly one cycle per frame, at (0,0). It is not asserted during reset or on the first cycle after release.
- Delayed outputs:
  - blank_d/hsync_d/vsync_d are the aligned signals passed through a PIPE_DELAY-stage shift register.
  - PIPE_DELAY=0 gives a combinational pass-through (identical to the aligned outputs).
- Reset mid-frame: counters return to (0,0) immediately and delay stages flush to inactive. After release the raster restarts from (0,0); no partial-line recovery.
- Frame period: 1344*806 = 1,083,264 cycles. No handshake; consumers sample freely.

Optional Feature:
- Macro: XVGA_FRAME_COUNT_EN.
- Defined: frame_count is an 8-bit register.
  - Increments by 1 on each cycle new_frame=1.
  - Wraps 255->0.
  - Reset to 0.
  - Menu blink and animation logic uses it.
- Undefined: port remains present, tied to 8'd0, no register inferred.

Decomposition:
- Shared package xvga_pkg holds:
  - all H_*/V_* constants;
  - derived sync start/end values (1048, 1184, 771, 777);
  - HCOUNT_W=11 and VCOUNT_W=10.
- One natural sub-module: sync_delay_line.
  - Parameters WIDTH and DEPTH; DEPTH=0 gives pass-through.
  - Asynchronous active-low reset to a parameterized RESET_VAL.
  - Instantiated once with WIDTH=3 for {blank,hsync,vsync}.

Test Plan:
- Reset behaviour: hold rst_n=0 for 5 cycles, then release. During reset: hcount=0, vcount=0, hsync=1, vsync=1, blank_d=1. First post-release cycle: hcount=1. new_frame low until the next (0,0).
- Line timing: run one line. hsync falls on the cycle hcount=1048 and rises at 1184 (136 cycles low). blank rises at hcount=1024. hcount wraps 1343->0 while vcount goes 0->1.
- Frame timing: run a full frame. vsync is low exactly for vcount 771..776. blank stays high for all of vcount>=768. new_frame pulses once; the next pulse comes exactly 1,083,264 cycles later.
- Delay alignment: with PIPE_DELAY=1, hsync_d falls when hcount=1049. With PIPE_DELAY=0, hsync_d==hsync on every cycle. With PIPE_DELAY=3, blank_d rises when hcount=1027.
- Mid-frame reset: assert rst_n=0 asynchronously (between clock edges) at vcount=400, hcount=700. Outputs go to reset values without waiting for a clock edge. After release, counting restarts at (0,0).
- Frame counter: with XVGA_FRAME_COUNT_EN defined, run 257 frames; frame_count reads 1 after the wrap. Undefined: frame_count stays 0 throughout.
